stream_to_memory: RTL



---
 rtl/stream_to_memory_pkg.sv | 17 +
 rtl/stream_to_memory_bank.sv | 66 ++++++
 rtl/stream_to_memory.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/stream_to_memory_pkg.sv
// stream_to_memory_pkg: shared types and helpers for the stream_to_memory deserialiser
package stream_to_memory_pkg;

    typedef enum logic {FILL, FULL} state_t;

    localparam int STATUS_COUNT_W = 16;

    typedef struct packed {
        logic [STATUS_COUNT_W-1:0] count;
        logic                      eow;
    } frame_status_t;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stream_to_memory_bank.sv
// stream_to_memory_bank: one frame buffer with a per-entry valid mask so unwritten entries read as zero
module stream_to_memory_bank
    import stream_to_memory_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int MEMORY_DEPTH = 20
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 we,
    input  logic [$clog2(MEMORY_DEPTH)-1:0]      widx,
    input  logic [DATA_WIDTH-1:0]                wdata,
    input  logic                                 close,
    input  logic [count_width(MEMORY_DEPTH)-1:0] close_count,
    input  logic                                 close_eow,
    input  logic                                 clear,
    output logic [DATA_WIDTH-1:0]                data_o [MEMORY_DEPTH],
    output logic [count_width(MEMORY_DEPTH)-1:0] count_o,
    output logic                                 eow_o
);
    localparam int CW = count_width(MEMORY_DEPTH);

    logic [DATA_WIDTH-1:0]   mem_q [MEMORY_DEPTH];
    logic [DATA_WIDTH-1:0]   mem_d [MEMORY_DEPTH];
    logic [MEMORY_DEPTH-1:0] valid_q, valid_d;
    frame_status_t           stat_q, stat_d;

    // write a word, mark it valid, latch frame status on close, drop everything on clear
    always_comb begin
        mem_d   = mem_q;
        valid_d = valid_q;
        stat_d  = stat_q;
        if (clear) begin
            valid_d = '0;
            stat_d  = '0;
        end
        if (we) begin
            mem_d[widx]   = wdata;
            valid_d[widx] = 1'b1;
        end
        if (close) stat_d = '{count: STATUS_COUNT_W'(close_count), eow: close_eow};
    end

    // storage needs no reset: the valid mask hides whatever it holds
    always_ff @(posedge clk) mem_q <= mem_d;

    // mask and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            stat_q  <= '0;
        end else begin
            valid_q <= valid_d;
            stat_q  <= stat_d;
        end
    end

    // stale entries beyond the written range read as zero
    always_comb begin
        for (int i = 0; i < MEMORY_DEPTH; i++) data_o[i] = valid_q[i] ? mem_q[i] : '0;
    end

    assign count_o = CW'(stat_q.count);
    assign eow_o   = stat_q.eow;

endmodule

// File: rtl/stream_to_memory.sv
// stream_to_memory: rebuild a parallel frame from an rts/rtr/eow word stream; STREAM_TO_MEMORY_PINGPONG_EN adds a second bank
module stream_to_memory
    import stream_to_memory_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int MEMORY_DEPTH = 20
) (
    input  logic                                 clk,
    input  logic                                 rst,
    output logic                                 rtr_o,
    input  logic                                 rts_i,
    input  logic                                 eow_i,
    input  logic [DATA_WIDTH-1:0]                data_i,
    input  logic                                 rtr_i,
    output logic                                 rts_o,
    output logic                                 eow_o,
    output logic [count_width(MEMORY_DEPTH)-1:0] count_o,
    output logic [DATA_WIDTH-1:0]                data_o [MEMORY_DEPTH]
);
    localparam int CW = count_width(MEMORY_DEPTH);
    localparam int IW = $clog2(MEMORY_DEPTH);
`ifdef STREAM_TO_MEMORY_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic [IW-1:0]         wc_q, wc_d;
    logic                  rtr_q, rtr_d;
    logic                  accept, close, release_frame;
    logic [CW-1:0]         close_count;
    logic [NB-1:0]         bank_we, bank_close, bank_clear, bank_eow;
    logic [DATA_WIDTH-1:0] bank_data [NB][MEMORY_DEPTH];
    logic [CW-1:0]         bank_count [NB];

    assign rtr_o       = rtr_q;
    assign accept      = rts_i & rtr_q;
    assign close       = accept & (eow_i | (wc_q == IW'(MEMORY_DEPTH - 1)));
    assign close_count = CW'(wc_q) + 1'b1;

    // write index: advances per accepted word, restarts when the frame closes
    always_comb begin
        wc_d = wc_q;
        if (accept) wc_d = close ? '0 : wc_q + 1'b1;
    end

    // rtr_q stays low during reset and rises one cycle after it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wc_q  <= '0;
            rtr_q <= 1'b0;
        end else begin
            wc_q  <= wc_d;
            rtr_q <= rtr_d;
        end
    end

`ifdef STREAM_TO_MEMORY_PINGPONG_EN
    state_t st_q [2];
    state_t st_d [2];
    logic   wp_q, wp_d, rp_q, rp_d;

    assign rts_o         = st_q[rp_q] == FULL;
    assign release_frame = rts_o & rtr_i;
    assign bank_we       = {accept & wp_q, accept & ~wp_q};
    assign bank_close    = {close & wp_q, close & ~wp_q};
    assign bank_clear    = {release_frame & rp_q, release_frame & ~rp_q};

    // fill pointer moves on close, present pointer on release; stall only when both banks hold frames
    always_comb begin
        st_d = st_q;
        if (close) st_d[wp_q] = FULL;
        if (release_frame) st_d[rp_q] = FILL;
        wp_d  = wp_q ^ close;
        rp_d  = rp_q ^ release_frame;
        rtr_d = !(st_d[0] == FULL && st_d[1] == FULL);
    end

    // bank states and pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q[0] <= FILL;
            st_q[1] <= FILL;
            wp_q    <= 1'b0;
            rp_q    <= 1'b0;
        end else begin
            st_q <= st_d;
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    // present the bank the read pointer selects
    always_comb begin
        data_o  = bank_data[rp_q];
        count_o = bank_count[rp_q];
        eow_o   = bank_eow[rp_q];
    end
`else
    state_t state_q, state_d;

    assign rts_o         = state_q == FULL;
    assign release_frame = rts_o & rtr_i;
    assign bank_we       = accept;
    assign bank_close    = close;
    assign bank_clear    = release_frame;

    // close hands the bank downstream; release returns it to filling
    always_comb begin
        state_d = state_q;
        if (close) state_d = FULL;
        else if (release_frame) state_d = FILL;
        rtr_d = state_d == FILL;
    end

    // frame state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FILL;
        else state_q <= state_d;
    end

    assign data_o  = bank_data[0];
    assign count_o = bank_count[0];
    assign eow_o   = bank_eow[0];
`endif

    for (genvar b = 0; b < NB; b++) begin : g_bank
        stream_to_memory_bank #(
            .DATA_WIDTH  (DATA_WIDTH),
            .MEMORY_DEPTH(MEMORY_DEPTH)
        ) u_bank (
            .clk        (clk),
            .rst        (rst),
            .we         (bank_we[b]),
            .widx       (wc_q),
            .wdata      (data_i),
            .close      (bank_close[b]),
            .close_count(close_count),
            .close_eow  (eow_i),
            .clear      (bank_clear[b]),
            .data_o     (bank_data[b]),
            .count_o    (bank_count[b]),
            .eow_o      (bank_eow[b])
        );
    end

endmodule
